// File: rtl/gpr_file.sv
// ---------------------------------------------------------------------------
// GprFile (module gpr_file)
//
// Integer register file that receives writebacks from wbu and serves two
// combinational read ports plus a pending-write scoreboard to idu.
//
// After reset the file walks every register and zeroes it, one index per
// cycle. It only accepts writes and scoreboard updates once that sweep is
// finished.
//
// Ports
//   i_clk               clock, all state updates on the rising edge
//   i_rst               synchronous active-high reset
//   i_sys_valid         wbu presents a writeback this cycle
//   o_sys_ready         file accepts writes (RUN state, not in reset)
//   i_wbu_gpr_wr_en     writeback carries a GPR write
//   i_wbu_gpr_wr_id     writeback destination index
//   i_wbu_gpr_wr_data   writeback data
//   i_idu_rs1_id        read port 1 index
//   i_idu_rs2_id        read port 2 index
//   o_idu_rs1_data      read port 1 data (write-first bypass)
//   o_idu_rs2_data      read port 2 data (write-first bypass)
//   i_idu_sb_set_en     idu issued an instruction that writes a GPR
//   i_idu_sb_set_id     destination of that instruction
//   o_idu_rs1_busy      rs1 has a pending write
//   o_idu_rs2_busy      rs2 has a pending write
// ---------------------------------------------------------------------------
module gpr_file #(
   parameter int DATA_WIDTH = 32,
   parameter int GPRS_WIDTH = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_sys_valid,
   output logic                  o_sys_ready,
   input  logic                  i_wbu_gpr_wr_en,
   input  logic [GPRS_WIDTH-1:0] i_wbu_gpr_wr_id,
   input  logic [DATA_WIDTH-1:0] i_wbu_gpr_wr_data,
   input  logic [GPRS_WIDTH-1:0] i_idu_rs1_id,
   input  logic [GPRS_WIDTH-1:0] i_idu_rs2_id,
   output logic [DATA_WIDTH-1:0] o_idu_rs1_data,
   output logic [DATA_WIDTH-1:0] o_idu_rs2_data,
   input  logic                  i_idu_sb_set_en,
   input  logic [GPRS_WIDTH-1:0] i_idu_sb_set_id,
   output logic                  o_idu_rs1_busy,
   output logic                  o_idu_rs2_busy
);

   localparam int GPRS_NUM = 2 ** GPRS_WIDTH;
   localparam logic [GPRS_WIDTH-1:0] LastIdx = GPRS_WIDTH'(GPRS_NUM - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [GPRS_WIDTH-1:0]   clrCnt_q, clrCnt_d;
   logic [GPRS_NUM-1:0]     sb_q, sb_d;
   logic [DATA_WIDTH-1:0]   gpr_q [GPRS_NUM];

   logic                    runActive;
   logic                    wrAcc;
   logic                    sbSet;
   logic                    gprWrEn;
   logic [GPRS_WIDTH-1:0]   gprWrIdx;
   logic [DATA_WIDTH-1:0]   gprWrData;

   // The file is usable only in RUN and only while reset is low, so a reset
   // arriving mid-operation blocks a write that is already on the port.
   always_comb begin
      runActive   = (state_q == ST_RUN) && !i_rst;
      o_sys_ready = runActive;
      wrAcc       = i_sys_valid && runActive && i_wbu_gpr_wr_en
                    && (i_wbu_gpr_wr_id != '0);
      sbSet       = i_idu_sb_set_en && runActive && (i_idu_sb_set_id != '0);
   end

   // The clear sweep advances one index per cycle and hands over to RUN
   // after the last index. The counter holds at the last index and never
   // wraps.
   always_comb begin
      state_d  = state_q;
      clrCnt_d = clrCnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (clrCnt_q == LastIdx) begin
               state_d = ST_RUN;
            end else begin
               clrCnt_d = clrCnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d  = ST_CLEAR;
            clrCnt_d = '0;
         end
      endcase
   end

   // This block holds the state, the sweep counter and the scoreboard.
   // Reset sends the file back to the start of the clear sweep and forgets
   // every pending producer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_CLEAR;
         clrCnt_q <= '0;
         sb_q     <= '0;
      end else begin
         state_q  <= state_d;
         clrCnt_q <= clrCnt_d;
         sb_q     <= sb_d;
      end
   end

   // A landing write clears its busy bit. A new issue sets its bit and
   // overrides a clear on the same index, because a newer producer is now
   // in flight. x0 never has a pending write.
   always_comb begin
      sb_d = sb_q;
      if (wrAcc) begin
         sb_d[i_wbu_gpr_wr_id] = 1'b0;
      end
      if (sbSet) begin
         sb_d[i_idu_sb_set_id] = 1'b1;
      end
      sb_d[0] = 1'b0;
   end

   // The storage array has a single write port. The clear sweep and
   // accepted writebacks share it. The two never overlap because writebacks
   // are only accepted in RUN.
   always_comb begin
      gprWrEn   = 1'b0;
      gprWrIdx  = i_wbu_gpr_wr_id;
      gprWrData = i_wbu_gpr_wr_data;
      if (!i_rst) begin
         if (state_q == ST_CLEAR) begin
            gprWrEn   = 1'b1;
            gprWrIdx  = clrCnt_q;
            gprWrData = '0;
         end else if (wrAcc) begin
            gprWrEn   = 1'b1;
         end
      end
   end

   // The storage itself has no reset. The post-reset sweep puts it into a
   // known state before the file ever reports ready.
   always_ff @(posedge i_clk) begin
      if (gprWrEn) begin
         gpr_q[gprWrIdx] <= gprWrData;
      end
   end

   // Read port 1. Outside RUN the port is forced to zero. x0 always reads
   // zero. A write landing on the same index this cycle is forwarded
   // (write-first), so idu sees the value in the same cycle.
   always_comb begin
      o_idu_rs1_data = '0;
      if (runActive && (i_idu_rs1_id != '0)) begin
         if (wrAcc && (i_wbu_gpr_wr_id == i_idu_rs1_id)) begin
            o_idu_rs1_data = i_wbu_gpr_wr_data;
         end else begin
            o_idu_rs1_data = gpr_q[i_idu_rs1_id];
         end
      end
   end

   // Read port 2 behaves exactly like read port 1.
   always_comb begin
      o_idu_rs2_data = '0;
      if (runActive && (i_idu_rs2_id != '0)) begin
         if (wrAcc && (i_wbu_gpr_wr_id == i_idu_rs2_id)) begin
            o_idu_rs2_data = i_wbu_gpr_wr_data;
         end else begin
            o_idu_rs2_data = gpr_q[i_idu_rs2_id];
         end
      end
   end

   // A write landing this cycle releases the hazard in the same cycle,
   // matching the data bypass. A simultaneous re-issue still sets the bit
   // for the following cycles.
   always_comb begin
      o_idu_rs1_busy = sb_q[i_idu_rs1_id]
                       && !(wrAcc && (i_wbu_gpr_wr_id == i_idu_rs1_id));
      o_idu_rs2_busy = sb_q[i_idu_rs2_id]
                       && !(wrAcc && (i_wbu_gpr_wr_id == i_idu_rs2_id));
   end

endmodule

// File: tb/tb_gpr_file.sv
// ---------------------------------------------------------------------------
// Bench for gpr_file.
//
// Stimulus tasks drive the ports right after a rising edge and push the
// values the outputs should show in that cycle into a queue. A separate
// monitor drains the queue on the falling edge and compares each entry
// against the live outputs.
// ---------------------------------------------------------------------------
module tb_gpr_file;

   localparam int DW = 32;
   localparam int GW = 5;

   typedef enum int {
      K_READY,
      K_RS1,
      K_RS2,
      K_BUSY1,
      K_BUSY2
   } kind_e;

   typedef struct {
      string       name;
      kind_e       kind;
      logic [31:0] value;
   } expItem_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          sysValid;
   logic          sysReady;
   logic          wrEn;
   logic [GW-1:0] wrId;
   logic [DW-1:0] wrData;
   logic [GW-1:0] rs1Id;
   logic [GW-1:0] rs2Id;
   logic [DW-1:0] rs1Data;
   logic [DW-1:0] rs2Data;
   logic          setEn;
   logic [GW-1:0] setId;
   logic          rs1Busy;
   logic          rs2Busy;

   expItem_t expQ[$];
   int       checks = 0;
   int       errors = 0;

   gpr_file #(
      .DATA_WIDTH(DW),
      .GPRS_WIDTH(GW)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_sys_valid      (sysValid),
      .o_sys_ready      (sysReady),
      .i_wbu_gpr_wr_en  (wrEn),
      .i_wbu_gpr_wr_id  (wrId),
      .i_wbu_gpr_wr_data(wrData),
      .i_idu_rs1_id     (rs1Id),
      .i_idu_rs2_id     (rs2Id),
      .o_idu_rs1_data   (rs1Data),
      .o_idu_rs2_data   (rs2Data),
      .i_idu_sb_set_en  (setEn),
      .i_idu_sb_set_id  (setId),
      .o_idu_rs1_busy   (rs1Busy),
      .o_idu_rs2_busy   (rs2Busy)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   // Bounds the whole run so that a stuck bench cannot hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compares one queued expectation against the live DUT outputs.
   task automatic checkOutput(input expItem_t item);
      logic [31:0] act;
      case (item.kind)
         K_READY: act = {31'd0, sysReady};
         K_RS1:   act = rs1Data;
         K_RS2:   act = rs2Data;
         K_BUSY1: act = {31'd0, rs1Busy};
         default: act = {31'd0, rs2Busy};
      endcase
      checks++;
      if (act !== item.value) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", item.name, act, item.value);
      end
   endtask

   // The monitor drains every expectation queued for the current cycle,
   // sampling away from the rising edge.
   always @(negedge clk) begin
      while (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   task automatic expectVal(input string name, input kind_e kind, input logic [31:0] value);
      expItem_t item;
      item.name  = name;
      item.kind  = kind;
      item.value = value;
      expQ.push_back(item);
   endtask

   // Drives one cycle's worth of inputs.
   task automatic applyStimulus(
      input logic          valid,
      input logic          en,
      input logic [GW-1:0] id,
      input logic [DW-1:0] data,
      input logic [GW-1:0] r1,
      input logic [GW-1:0] r2,
      input logic          sEn,
      input logic [GW-1:0] sId
   );
      sysValid = valid;
      wrEn     = en;
      wrId     = id;
      wrData   = data;
      rs1Id    = r1;
      rs2Id    = r2;
      setEn    = sEn;
      setId    = sId;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Releases reset and walks the clear sweep. Ready must stay low for
   // exactly 32 cycles and rise in cycle 32. A write to x3 is attempted
   // during the sweep, and x3 must still read 0 once RUN is reached.
   task automatic runClearSweep(input string tag);
      rst = 1'b0;
      for (int k = 0; k <= 32; k++) begin
         if (k == 5) begin
            applyStimulus(1'b1, 1'b1, 5'd3, 32'd5, 5'd3, 5'd0, 1'b0, 5'd0);
         end else begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b0, 5'd0);
         end
         expectVal($sformatf("%s_ready_c%0d", tag, k), K_READY, (k >= 32) ? 32'd1 : 32'd0);
         if (k == 5 || k == 32) begin
            expectVal($sformatf("%s_x3_c%0d", tag, k), K_RS1, 32'd0);
         end
         stepCycle();
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
      stepCycle();
      stepCycle();
      stepCycle();
      expectVal("reset_ready", K_READY, 32'd0);
      expectVal("reset_rs1", K_RS1, 32'd0);
      expectVal("reset_busy2", K_BUSY2, 32'd0);
      stepCycle();

      runClearSweep("sweep1");

      // Every register reads 0 after the sweep, on both ports.
      for (int r = 0; r < 32; r++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'(r), 5'(31 - r), 1'b0, 5'd0);
         expectVal($sformatf("zero_rs1_x%0d", r), K_RS1, 32'd0);
         expectVal($sformatf("zero_rs2_x%0d", 31 - r), K_RS2, 32'd0);
         stepCycle();
      end

      // Write x5 = DEADBEEF. The value is bypassed in the same cycle and
      // then read from storage afterwards.
      applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0);
      expectVal("x5_bypass", K_RS1, 32'hDEADBEEF);
      expectVal("x5_bypass_rs2_x0", K_RS2, 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0);
      expectVal("x5_stored_rs1", K_RS1, 32'hDEADBEEF);
      expectVal("x5_stored_rs2", K_RS2, 32'hDEADBEEF);
      stepCycle();

      // Neither valid-without-enable nor enable-without-valid may write.
      applyStimulus(1'b1, 1'b0, 5'd5, 32'h1111, 5'd5, 5'd0, 1'b0, 5'd0);
      expectVal("noen_nobypass", K_RS1, 32'hDEADBEEF);
      stepCycle();
      applyStimulus(1'b0, 1'b1, 5'd5, 32'h2222, 5'd5, 5'd0, 1'b0, 5'd0);
      expectVal("novalid_nobypass", K_RS1, 32'hDEADBEEF);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0);
      expectVal("x5_unchanged", K_RS1, 32'hDEADBEEF);
      stepCycle();

      // A write or scoreboard set aimed at x0 is discarded.
      applyStimulus(1'b1, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b1, 5'd0);
      expectVal("x0_wr_rs1", K_RS1, 32'd0);
      expectVal("x0_wr_rs2", K_RS2, 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
      expectVal("x0_after_rs1", K_RS1, 32'd0);
      expectVal("x0_after_busy1", K_BUSY1, 32'd0);
      expectVal("x0_after_busy2", K_BUSY2, 32'd0);
      stepCycle();

      // Scoreboard sequence on x7.
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b1, 5'd7);
      expectVal("sb_set_same_cycle", K_BUSY2, 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 5'd0);
      expectVal("sb_x7_busy2", K_BUSY2, 32'd1);
      expectVal("sb_x7_busy1", K_BUSY1, 32'd1);
      stepCycle();
      applyStimulus(1'b1, 1'b1, 5'd7, 32'd9, 5'd0, 5'd7, 1'b0, 5'd0);
      expectVal("sb_wr_release", K_BUSY2, 32'd0);
      expectVal("sb_wr_bypass", K_RS2, 32'd9);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b0, 5'd0);
      expectVal("sb_cleared", K_BUSY2, 32'd0);
      expectVal("sb_x7_data", K_RS2, 32'd9);
      stepCycle();
      applyStimulus(1'b1, 1'b1, 5'd7, 32'd20, 5'd0, 5'd7, 1'b1, 5'd7);
      expectVal("sb_setwr_now", K_BUSY2, 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b0, 5'd0);
      expectVal("sb_setwr_after", K_BUSY2, 32'd1);
      expectVal("sb_setwr_data", K_RS2, 32'd20);
      stepCycle();
      applyStimulus(1'b1, 1'b1, 5'd7, 32'd21, 5'd7, 5'd0, 1'b1, 5'd7);
      expectVal("sb_busy_setwr_now", K_BUSY1, 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0, 5'd0);
      expectVal("sb_busy_setwr_after", K_BUSY1, 32'd1);
      expectVal("sb_busy_setwr_data", K_RS1, 32'd21);
      stepCycle();
      applyStimulus(1'b1, 1'b1, 5'd7, 32'd22, 5'd7, 5'd0, 1'b0, 5'd0);
      expectVal("sb_final_release", K_BUSY1, 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b0, 5'd0);
      expectVal("sb_final_clear", K_BUSY1, 32'd0);
      expectVal("sb_final_data", K_RS1, 32'd22);
      stepCycle();

      // Leave x12 pending. Then assert reset in RUN together with a write.
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd12);
      stepCycle();
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 5'd9, 5'd12, 1'b0, 5'd0);
      expectVal("rst_run_ready", K_READY, 32'd0);
      expectVal("rst_run_rs1", K_RS1, 32'd0);
      stepCycle();

      // Release reset, let the sweep reach index 10, then reset again.
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
      for (int k = 0; k < 10; k++) begin
         stepCycle();
      end
      expectVal("mid_clear_ready", K_READY, 32'd0);
      rst = 1'b1;
      stepCycle();

      runClearSweep("sweep2");

      // Everything is cleared: data, the dropped write and the scoreboard.
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd12, 1'b0, 5'd0);
      expectVal("post_rst_x5", K_RS1, 32'd0);
      expectVal("post_rst_busy12", K_BUSY2, 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd7, 1'b0, 5'd0);
      expectVal("post_rst_x9", K_RS1, 32'd0);
      expectVal("post_rst_x7", K_RS2, 32'd0);
      expectVal("post_rst_busy7", K_BUSY2, 32'd0);
      stepCycle();
      stepCycle();

      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL queue_drain: got %0d, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
